rr_arb_mux: RTL and testbench

Registered N-input round-robin arbitrating multiplexer with per-input valid/ready handshakes and a one-entry output stage. It merges N_INS producer streams (e.g. functional-unit result buses, issue-queue wakeup sources) onto one consumer port. The arbiter is fair and starvation-free. The one-hot grant is generated internally, so it is one-hot by construction.

---
 rtl/global_defs.sv | 7 +
 rtl/rr_arbiter.sv | 22 ++
 rtl/rr_arb_mux.sv | 72 +++++++
 tb/tb_rr_arb_mux.sv | 117 +++++++++++
 4 files changed

// File: rtl/global_defs.sv
// global_defs: shared types and sizing helpers for the arbiter family.
package global_defs;
  typedef enum logic {EDGE_POS, EDGE_NEG} edge_t;
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant from a rotating priority pointer.
module rr_arbiter
  import global_defs::*;
#(
  parameter int N_INS = 4,
  localparam int SRC_W = src_w(N_INS)
) (
  input  logic [N_INS-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [N_INS-1:0] grant,
  output logic [SRC_W-1:0] grant_idx
);
  localparam int D = 2 * N_INS;
  logic [D-1:0] w_dbl;
  // Upper copy is never masked, so wrap-around requests are still found.
  always_comb begin
    w_dbl = {req, req} & ~((D'(1) << ptr) - D'(1));
    grant_idx = '0;
    for (int j = D - 1; j >= 0; j--) if (w_dbl[j]) grant_idx = SRC_W'(j % N_INS);
    grant = (|req) ? (N_INS'(1) << grant_idx) : '0;
  end
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered round-robin N:1 valid/ready mux with one-entry output stage.
// RR_ARB_MUX_ASSERT_EN enables simulation-only protocol checks.
module rr_arb_mux
  import global_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int N_INS = 4,
  localparam int SRC_W = src_w(N_INS)
) (
  input  logic                        clk,
  input  logic                        rst_aL,
  input  logic [N_INS-1:0]            in_valid,
  input  logic [N_INS-1:0][WIDTH-1:0] in_data,
  output logic [N_INS-1:0]            in_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [SRC_W-1:0]            out_src,
  input  logic                        out_ready
);
  logic [SRC_W-1:0] r_ptr;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SRC_W-1:0] r_src;
  logic [N_INS-1:0] w_grant;
  logic [SRC_W-1:0] w_idx;
  logic             w_load_en;
  logic             w_xfer;
  rr_arbiter #(.N_INS(N_INS)) u_arb (
    .req       (in_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_idx)
  );
  // Gating with rst_aL keeps producers from seeing an accept during reset.
  assign w_load_en = rst_aL & (!r_valid | out_ready);
  assign in_ready  = w_grant & {N_INS{w_load_en}};
  assign w_xfer    = |in_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_src   = r_src;
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= in_data[w_idx];
      r_src   <= w_idx;
      r_ptr   <= (w_idx == SRC_W'(N_INS - 1)) ? '0 : w_idx + 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end
`ifdef RR_ARB_MUX_ASSERT_EN
  edge_t w_chk_edge;
  assign w_chk_edge = EDGE_POS;
  a_onehot: assert property (@(posedge clk) disable iff (!rst_aL) $onehot0(in_ready))
    else $error("%s: in_ready not onehot0 in_ready=%b", w_chk_edge.name(), in_ready);
  a_subset: assert property (@(posedge clk) disable iff (!rst_aL) (in_ready & ~in_valid) == '0)
    else $error("%s: in_ready=%b not within in_valid=%b", w_chk_edge.name(), in_ready, in_valid);
  a_out_hold: assert property (@(posedge clk) disable iff (!rst_aL)
    out_valid && !out_ready |=> $stable(out_data) && $stable(out_src))
    else $error("%s: output changed under backpressure data=%h src=%0d", w_chk_edge.name(), out_data, out_src);
  for (genvar i = 0; i < N_INS; i++) begin : g_hold
    a_in_hold: assert property (@(posedge clk) disable iff (!rst_aL)
      in_valid[i] && !in_ready[i] |=> in_valid[i] && $stable(in_data[i]))
      else $error("%s: channel %0d dropped request valid=%b data=%h", w_chk_edge.name(), i, in_valid, in_data[i]);
  end
`endif
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed self-checking bench for rr_arb_mux with N_INS=4, WIDTH=8.
module tb_rr_arb_mux;
  logic            clk = 1'b0;
  logic            rst_aL;
  logic [3:0]      in_valid;
  logic [3:0][7:0] in_data;
  logic [3:0]      in_ready;
  logic            out_valid;
  logic [7:0]      out_data;
  logic [1:0]      out_src;
  logic            out_ready;
  int checks = 0;
  int errors = 0;
  rr_arb_mux #(.WIDTH(8), .N_INS(4)) dut (
    .clk       (clk),
    .rst_aL    (rst_aL),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_src"}, 32'(out_src), 32'(s));
  endtask
  initial begin
    rst_aL = 1'b0;
    in_valid = 4'hF;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;
    #1;
    chk_out("reset", 1'b0, 8'h00, 2'd0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    chk_out("reset_held", 1'b0, 8'h00, 2'd0);
    chk("reset_held_in_ready", 32'(in_ready), 32'h0);
    rst_aL = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_out("contention", 1'b1, 8'(8'h10 + (k % 4)), 2'(k % 4));
    end
    in_valid = 4'b0010;
    @(negedge clk);
    chk_out("skip_prep", 1'b1, 8'h11, 2'd1);
    in_valid = 4'b1010;
    in_data = {8'h23, 8'h12, 8'h21, 8'h10};
    #1;
    chk("skip_ready_3", 32'(in_ready), 32'b1000);
    @(negedge clk);
    chk_out("skip_grant_3", 1'b1, 8'h23, 2'd3);
    chk("skip_ready_1", 32'(in_ready), 32'b0010);
    @(negedge clk);
    chk_out("skip_grant_1", 1'b1, 8'h21, 2'd1);
    chk("skip_ptr_back_2", 32'(in_ready), 32'b1000);
    in_valid = 4'b0100;
    in_data = {8'h13, 8'hA5, 8'h11, 8'h10};
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 4'hF;
    #1;
    chk_out("bp", 1'b1, 8'hA5, 2'd2);
    chk("bp_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    chk_out("bp_held", 1'b1, 8'hA5, 2'd2);
    chk("bp_held_in_ready", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    #1;
    chk("bp_ptr_3", 32'(in_ready), 32'b1000);
    @(negedge clk);
    chk_out("bp_release", 1'b1, 8'h13, 2'd3);
    in_valid = 4'b0001;
    in_data = {8'h13, 8'h12, 8'h11, 8'h3C};
    @(negedge clk);
    chk_out("drain_load", 1'b1, 8'h3C, 2'd0);
    in_valid = 4'b0000;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    chk_out("drain_only", 1'b0, 8'h3C, 2'd0);
    in_valid = 4'b0100;
    @(negedge clk);
    in_valid = 4'b0000;
    out_ready = 1'b0;
    chk_out("mid_prep", 1'b1, 8'h12, 2'd2);
    rst_aL = 1'b0;
    #1;
    chk_out("mid_reset", 1'b0, 8'h00, 2'd0);
    in_valid = 4'hF;
    out_ready = 1'b1;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    #1;
    chk("mid_reset_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    chk_out("mid_reset_held", 1'b0, 8'h00, 2'd0);
    rst_aL = 1'b1;
    #1;
    chk("mid_release_ptr0", 32'(in_ready), 32'b0001);
    @(negedge clk);
    chk_out("mid_first_grant", 1'b1, 8'h10, 2'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
